// File: rtl/tff_ctrl_pkg.sv
// Shared types for the toggle-flop counter controller: FSM state encoding and default bank width.
package tff_ctrl_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/tff_cell.sv
// One toggle flop built from an SR flop: set when toggling a 0, reset when toggling a 1 (never S=R=1).
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q;
  logic w_s;
  logic w_r;

  assign w_s = t & ~r_q;
  assign w_r = t &  r_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)      r_q <= 1'b0;
    else if (w_s) r_q <= 1'b1;
    else if (w_r) r_q <= 1'b0;
  end

  assign q = r_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Controller that sequences toggle enables into a W-bit toggle-flop bank so it counts to a target.
// Down counting and the dir port exist only when TFF_CTRL_DOWN_EN is defined.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] target,
  input  logic         load,
  input  logic [W-1:0] load_val,
`ifdef TFF_CTRL_DOWN_EN
  input  logic         dir,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] t_vec
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_target;
  logic [W-1:0] w_q;
  logic [W-1:0] w_t_vec;
  logic [W-1:0] w_t_cnt;
  logic         w_capture;

`ifdef TFF_CTRL_DOWN_EN
  logic r_dir;
`endif

  // Per-bit toggle enables for a +1 (bit toggles when all lower bits are 1) or a -1 (all lower bits 0).
  always_comb begin : cnt_toggles
    logic carry;
    logic borrow;
    logic [W-1:0] t_up;
    logic [W-1:0] t_dn;
    // NOTE: combinational blocks use blocking (=) and assign every output first, so no latch is inferred.
    carry  = 1'b1;
    borrow = 1'b1;
    t_up   = '0;
    t_dn   = '0;
    for (int i = 0; i < W; i++) begin
      t_up[i] = carry;
      t_dn[i] = borrow;
      carry   = carry  &  w_q[i];
      borrow  = borrow & ~w_q[i];
    end
`ifdef TFF_CTRL_DOWN_EN
    w_t_cnt = r_dir ? t_dn : t_up;
`else
    w_t_cnt = t_up;
`endif
  end

  always_comb begin
    w_next    = r_state;
    w_t_vec   = '0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_t_vec = w_q ^ load_val;
        end else if (start) begin
          w_capture = 1'b1;
          w_next    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_q == r_target) w_next  = ST_DONE;
        else                 w_t_vec = w_t_cnt;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (rst) w_t_vec = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_target <= target;
    end
  end

`ifdef TFF_CTRL_DOWN_EN
  always_ff @(posedge clk) begin
    if (rst)            r_dir <= 1'b0;
    else if (w_capture) r_dir <= dir;
  end
`endif

  for (genvar i = 0; i < W; i++) begin : g_bank
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (w_t_vec[i]),
      .q   (w_q[i])
    );
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign q     = w_q;
  assign t_vec = w_t_vec;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench for tff_count_ctrl: stimulus queues the expected per-cycle outputs, a monitor compares them.
module tb_tff_count_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] target;
  logic         load;
  logic [W-1:0] load_val;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] t_vec;
`ifdef TFF_CTRL_DOWN_EN
  logic         dir;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic [W-1:0] t_vec;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] m_q;

  tff_count_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .load     (load),
    .load_val (load_val),
`ifdef TFF_CTRL_DOWN_EN
    .dir      (dir),
`endif
    .busy     (busy),
    .done     (done),
    .q        (q),
    .t_vec    (t_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: mid-cycle sample of every output against the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q",     q,              e.q);
      check("busy",  W'(busy),       W'(e.busy));
      check("done",  W'(done),       W'(e.done));
      check("t_vec", t_vec,          e.t_vec);
    end
  end

  // Queue the outputs expected during the current cycle, then advance one clock.
  task automatic cyc(input logic [W-1:0] eq, input logic eb, input logic ed, input logic [W-1:0] et);
    exp_t e;
    e.q = eq; e.busy = eb; e.done = ed; e.t_vec = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(m_q, 1'b0, 1'b0, '0);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(m_q, 1'b0, 1'b0, m_q ^ v);
    load     = 1'b0;
    m_q      = v;
  endtask

  // Start a run to tgt; load is held high during RUN/DONE to show it is ignored there.
  task automatic run_seq(input logic [W-1:0] tgt, input logic down);
    logic [W-1:0] nxt;
    start  = 1'b1;
    target = tgt;
`ifdef TFF_CTRL_DOWN_EN
    dir    = down;
`endif
    cyc(m_q, 1'b0, 1'b0, '0);
    start    = 1'b0;
    target   = ~tgt;
    load     = 1'b1;
    load_val = 8'hFF;
    while (m_q != tgt) begin
      nxt = down ? m_q - 8'd1 : m_q + 8'd1;
      cyc(m_q, 1'b1, 1'b0, m_q ^ nxt);
      m_q = nxt;
    end
    cyc(m_q, 1'b1, 1'b0, '0);
    cyc(m_q, 1'b0, 1'b1, '0);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; load = 1'b0; target = '0; load_val = '0;
`ifdef TFF_CTRL_DOWN_EN
    dir = 1'b0;
`endif
    @(posedge clk);
    #1;
    // Reset held a second cycle: bank cleared, no enables.
    cyc(8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    m_q = 8'h00;

    do_load(8'hA5);
    idle(1);

    do_load(8'h00);
    run_seq(8'h05, 1'b0);
    idle(1);

    // Up count across the all-ones wrap.
    do_load(8'hFE);
    run_seq(8'h01, 1'b0);
    idle(2);

    // Reset mid-run: aborts with no done pulse.
    do_load(8'h03);
    start = 1'b1; target = 8'h10;
    cyc(8'h03, 1'b0, 1'b0, 8'h00);
    start = 1'b0;
    cyc(8'h03, 1'b1, 1'b0, 8'h03 ^ 8'h04);
    cyc(8'h04, 1'b1, 1'b0, 8'h04 ^ 8'h05);
    rst = 1'b1;
    cyc(8'h05, 1'b1, 1'b0, 8'h00);
    rst = 1'b0;
    m_q = 8'h00;
    idle(3);

    // Load and start together: load wins, no run.
    start = 1'b1; load = 1'b1; load_val = 8'h3C; target = 8'h55;
    cyc(8'h00, 1'b0, 1'b0, 8'h3C);
    start = 1'b0; load = 1'b0;
    m_q = 8'h3C;
    idle(2);

    // Target equals current value: one idle RUN cycle then DONE.
    run_seq(8'h3C, 1'b0);
    idle(1);

`ifdef TFF_CTRL_DOWN_EN
    do_load(8'h03);
    run_seq(8'h00, 1'b1);
    idle(1);
    run_seq(8'hFE, 1'b1);
    idle(1);
`endif

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
